// File: rtl/my_ram_8_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of one my_ram_8.
// Requesters A and B issue single-word reads/writes with a req/gnt handshake.
// Winners are serialised onto the single RAM port. Each access takes one
// IDLE (arbitrate) cycle plus one ACCESS cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A command (held until a_gnt)
//   a_gnt                      A access performed this cycle (1-cycle pulse)
//   a_rvalid/a_rdata           A read result (pulse / held data)
//   b_*                        same seven ports for requester B
//   ram_in/ram_addr/ram_load   drive the RAM write/read port
//   ram_out                    RAM combinational read data of ram_addr
module my_ram_8_arbiter #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned START_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  // requester A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  // requester B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  // RAM port
  output logic [WIDTH-1:0]  ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic START_PRIO_B = 1'(START_PRIO);

  state_t             state_q;
  logic               prio_q;    // 0: A wins a tie, 1: B wins a tie
  logic               sel_q;     // requester being served (0: A, 1: B)
  logic               we_q;
  logic               a_gnt_q, b_gnt_q;
  logic               a_rvalid_q, b_rvalid_q;
  logic [WIDTH-1:0]   a_rdata_q, b_rdata_q;
  logic [WIDTH-1:0]   ram_in_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic               ram_load_q;

  // Winner selection and the command fields of the winner
  logic               sel_d;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [WIDTH-1:0]   wdata_d;

  always_comb begin
    sel_d   = 1'b0;
    we_d    = a_we;
    addr_d  = a_addr;
    wdata_d = a_wdata;
    // B wins when it is the sole requester, or on a tie while holding priority
    if (b_req && (!a_req || prio_q)) begin
      sel_d = 1'b1;
    end
    if (sel_d) begin
      we_d    = b_we;
      addr_d  = b_addr;
      wdata_d = b_wdata;
    end
  end

  // FSM with registered outputs; RAM command is set up at the arbitration
  // edge so it is presented during the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= START_PRIO_B;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      ram_in_q   <= '0;
      ram_addr_q <= '0;
      ram_load_q <= 1'b0;
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      ram_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            sel_q      <= sel_d;
            we_q       <= we_d;
            ram_addr_q <= addr_d;
            ram_in_q   <= wdata_d;
            ram_load_q <= we_d;
            a_gnt_q    <= ~sel_d;
            b_gnt_q    <= sel_d;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data is captured while the address is still on the RAM port
          if (!we_q) begin
            if (sel_q) begin
              b_rdata_q  <= ram_out;
              b_rvalid_q <= 1'b1;
            end else begin
              a_rdata_q  <= ram_out;
              a_rvalid_q <= 1'b1;
            end
          end
          prio_q  <= ~sel_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign ram_in   = ram_in_q;
  assign ram_addr = ram_addr_q;
  assign ram_load = ram_load_q;

endmodule

// File: tb/tb_my_ram_8_arbiter.sv
// Self-checking bench for my_ram_8_arbiter: a behavioural RAM attached to the
// RAM port, queue-driven requesters, a transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized phase.
module tb_my_ram_8_arbiter;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned START_PRIO = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load;
  logic [W-1:0]  a_rdata, b_rdata, ram_in, ram_out;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  my_ram_8_arbiter #(.WIDTH(W), .ADDR_W(AW), .START_PRIO(START_PRIO)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
  );

  // Behavioural my_ram_8: combinational read, write on posedge with load
  logic [W-1:0] ram_mem [8];
  initial for (int i = 0; i < 8; i++) ram_mem[i] = '0;
  always @(posedge clk) if (ram_load) ram_mem[ram_addr] <= ram_in;
  assign ram_out = ram_mem[ram_addr];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wd;
  } op_t;

  typedef struct {
    int id;
    int cyc;
  } gev_t;

  op_t  qa[$], qb[$];
  op_t  cur_a = '0, cur_b = '0;
  bit   cur_a_v = 0, cur_b_v = 0;
  gev_t glog[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  // Reference model: shadow memory, priority, the access scheduled for the
  // current cycle, and the expected outputs for the current cycle.
  logic [W-1:0]  m_mem [8];
  bit            m_acc = 0, m_sel = 0, m_we = 0;
  bit            m_prio = 1'(START_PRIO);
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_wd = '0;
  logic          e_a_gnt = 0, e_b_gnt = 0, e_a_rv = 0, e_b_rv = 0, e_load = 0;
  logic [W-1:0]  e_a_rd = '0, e_b_rd = '0, e_ram_in = '0;
  logic [AW-1:0] e_ram_addr = '0;
  initial for (int i = 0; i < 8; i++) m_mem[i] = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic op_t mk(input bit we, input int unsigned addr, input int unsigned wd);
    op_t o;
    o.we   = we;
    o.addr = AW'(addr);
    o.wd   = W'(wd);
    return o;
  endfunction

  // Advance the model across the next posedge using the inputs now driven
  task automatic model_step();
    if (m_acc && m_we) m_mem[m_addr] = m_wd;  // a driven write lands even under reset
    e_a_gnt = 0; e_b_gnt = 0; e_a_rv = 0; e_b_rv = 0; e_load = 0;
    if (reset) begin
      m_prio = 1'(START_PRIO);
      m_acc  = 0;
      e_a_rd = '0; e_b_rd = '0; e_ram_in = '0; e_ram_addr = '0;
    end else if (m_acc) begin
      if (!m_we) begin
        if (m_sel) begin e_b_rd = m_mem[m_addr]; e_b_rv = 1; end
        else       begin e_a_rd = m_mem[m_addr]; e_a_rv = 1; end
      end
      m_prio = !m_sel;
      m_acc  = 0;
    end else if (a_req || b_req) begin
      m_sel = (a_req && b_req) ? m_prio : b_req;
      if (m_sel) begin m_we = b_we; m_addr = b_addr; m_wd = b_wdata; e_b_gnt = 1; end
      else       begin m_we = a_we; m_addr = a_addr; m_wd = a_wdata; e_a_gnt = 1; end
      m_acc      = 1;
      e_load     = m_we;
      e_ram_addr = m_addr;
      e_ram_in   = m_wd;
    end
  endtask

  // One cycle: compare outputs, advance requesters, drive inputs, step model
  task automatic step(input bit rst);
    @(negedge clk);
    cyc++;
    chk("a_gnt",    32'(a_gnt),    32'(e_a_gnt));
    chk("b_gnt",    32'(b_gnt),    32'(e_b_gnt));
    chk("a_rvalid", 32'(a_rvalid), 32'(e_a_rv));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_b_rv));
    chk("a_rdata",  32'(a_rdata),  32'(e_a_rd));
    chk("b_rdata",  32'(b_rdata),  32'(e_b_rd));
    chk("ram_load", 32'(ram_load), 32'(e_load));
    chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
    chk("ram_in",   32'(ram_in),   32'(e_ram_in));
    if (a_gnt === 1'b1) glog.push_back('{0, cyc});
    if (b_gnt === 1'b1) glog.push_back('{1, cyc});
    if (e_a_gnt) cur_a_v = 0;
    if (e_b_gnt) cur_b_v = 0;
    if (!cur_a_v && qa.size() > 0) begin cur_a = qa.pop_front(); cur_a_v = 1; end
    if (!cur_b_v && qb.size() > 0) begin cur_b = qb.pop_front(); cur_b_v = 1; end
    reset   = rst;
    a_req   = cur_a_v; a_we = cur_a.we; a_addr = cur_a.addr; a_wdata = cur_a.wd;
    b_req   = cur_b_v; b_we = cur_b.we; b_addr = cur_b.addr; b_wdata = cur_b.wd;
    model_step();
  endtask

  task automatic drain();
    int guard = 0;
    while ((qa.size() > 0 || qb.size() > 0 || cur_a_v || cur_b_v || m_acc) && guard < 300) begin
      step(0);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d cycles required < 300", guard);
    end
    step(0);
    step(0);
  endtask

  initial begin
    // 1: reset two cycles, then idle outputs
    step(1);
    step(1);
    for (int i = 0; i < 4; i++) step(0);
    chk("t1_ram_load", 32'(ram_load), 32'h0);
    chk("t1_a_rdata",  32'(a_rdata),  32'h0);
    chk("t1_b_gnt",    32'(b_gnt),    32'h0);

    // 2: A write 5 @3, then A read @3
    glog.delete();
    qa.push_back(mk(1, 3, 5));
    qa.push_back(mk(0, 3, 0));
    drain();
    chk("t2_ngnt", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("t2_gap", 32'(glog[1].cyc - glog[0].cyc), 32'd2);
    chk("t2_a_rdata", 32'(a_rdata), 32'h5);

    // 3: simultaneous writes to @1 after reset, A first; A read sees B's data
    step(1);
    glog.delete();
    qa.push_back(mk(1, 1, 16'h00AA));
    qa.push_back(mk(0, 1, 0));
    qb.push_back(mk(1, 1, 16'h00BB));
    drain();
    chk("t3_ngnt", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("t3_first_a", 32'(glog[0].id), 32'd0);
      chk("t3_then_b",  32'(glog[1].id), 32'd1);
      chk("t3_b_gap",   32'(glog[1].cyc - glog[0].cyc), 32'd2);
    end
    chk("t3_a_rdata", 32'(a_rdata), 32'h00BB);

    // 4: continuous reads from both sides alternate every 2 cycles
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(0, i, 0));
      qb.push_back(mk(0, 7 - i, 0));
    end
    drain();
    chk("t4_ngnt", 32'(glog.size()), 32'd8);
    if (glog.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        chk("t4_alt", 32'(glog[i].id != glog[i-1].id), 32'd1);
        chk("t4_gap", 32'(glog[i].cyc - glog[i-1].cyc), 32'd2);
      end
      chk("t4_span", 32'(glog[7].cyc - glog[0].cyc), 32'd14);
    end

    // 5: reset in the ACCESS cycle of an A read
    qa.push_back(mk(0, 5, 0));
    begin
      int guard = 0;
      while (!e_a_gnt && guard < 50) begin step(0); guard++; end
      if (guard >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL t5_grant_timeout: got %0d cycles required < 50", guard);
      end
    end
    step(1);  // ACCESS cycle; reset sampled at its closing edge
    step(0);
    chk("t5_no_rvalid", 32'(a_rvalid), 32'h0);
    chk("t5_rdata_clr", 32'(a_rdata),  32'h0);
    glog.delete();
    qa.push_back(mk(0, 2, 0));
    qb.push_back(mk(0, 2, 0));
    drain();
    if (glog.size() > 0) chk("t5_prio_a", 32'(glog[0].id), 32'd0);
    else chk("t5_prio_ngnt", 32'(glog.size()), 32'd2);
    glog.delete();
    qb.push_back(mk(0, 4, 0));
    drain();
    chk("t5_b_only", 32'(glog.size()), 32'd1);

    // 6: B writes at the address extremes; A traffic leaves b_rdata alone
    qb.push_back(mk(1, 7, 9));
    qb.push_back(mk(0, 7, 0));
    drain();
    chk("t6_b_rd7", 32'(b_rdata), 32'h9);
    qb.push_back(mk(1, 0, 2));
    qb.push_back(mk(0, 0, 0));
    drain();
    chk("t6_b_rd0", 32'(b_rdata), 32'h2);
    qa.push_back(mk(0, 7, 0));
    qa.push_back(mk(1, 5, 16'h1234));
    drain();
    chk("t6_b_keep", 32'(b_rdata), 32'h2);
    chk("t6_a_rd7",  32'(a_rdata), 32'h9);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if (!cur_a_v && qa.size() == 0 && $urandom_range(2) == 0)
        qa.push_back(mk(1'($urandom_range(1)), $urandom_range(7), $urandom));
      if (!cur_b_v && qb.size() == 0 && $urandom_range(2) == 0)
        qb.push_back(mk(1'($urandom_range(1)), $urandom_range(7), $urandom));
      step($urandom_range(99) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
